ika2151_regwr_sched: RTL and testbench
======================================

# ika2151_regwr_sched

Register-write scheduler between the CPU bus and the IKA2151 per-slot register file. Captures CPU address/data writes and raises the BUSY flag. Holds each data write until the 32-slot operator cycle reaches the slot that owns the target register, then issues a single one-cycle write strobe to the register file. Slot position comes from a local 5-bit counter that locks to the timing generator's `i_CYCLE_31` flag.

## Interface
- `BUSY_CYCLES`, default 32: BUSY duration in phi1 cycles. Must be ≥32 so any commit completes inside BUSY.
- `i_EMUCLK`  in  1  emulator master clock; the block's only clock.
- `i_MRST_n`  in  1  reset, asynchronous assert, active-low; clears all state.
- `i_phi1_NCEN_n`  in  1  phi1 negative-edge clock enable, active-low. All scheduler state advances only on this enable.
- `i_CYCLE_31`  in  1  high during the phi1 cycle the block treats as slot 31.
- `i_CS_n`, `i_WR_n`, `i_A0`  in  1 each  CPU bus strobes and register select.
- `i_D`  in  8  CPU write data.
- `o_BUSY`  out  1  CPU-visible busy flag.
- `o_REG_WE`  out  1  register-file write strobe, one phi1 cycle wide.
- `o_REG_ADDR`  out  8  register address; valid while `o_REG_WE`.
- `o_REG_DATA`  out  8  register data; valid while `o_REG_WE`.
- `o_SLOT`  out  5  local slot counter, for debug and bench.

## Operation
- **Bus capture** (every `i_EMUCLK`):
  - `i_CS_n`, `i_WR_n`, `i_A0` and `i_D` pass through a 2-stage synchronizer.
  - A write is a rising edge of the synchronized WR_n while the synchronized CS_n is low. A0 and D are taken from the synchronized sample taken before the edge.
  - A0=0: load the address latch. Always accepted, even while busy.
  - A0=1: a data write. Accepted if the scheduler is IDLE; the pending entry captures {address latch, D}.
  - A data write while busy is handled per Configuration.
- **Slot counter**: advances on each enable. It loads 0 on the enable after `i_CYCLE_31` is seen high; otherwise it increments and wraps 31→0.
- **Target slot match**, by the pending address:
  - 0x00–0x1F (global): matches any slot, so the write commits on the first enable after acceptance.
  - 0x20–0x3F (channel): matches when slot[2:0] == addr[2:0].
  - 0x40–0xFF (operator): matches when slot == addr[4:0].
- **FSM** (advances on enable):
  - IDLE → WAIT on an accepted data write.
  - WAIT → COMMIT when the slot matches.
  - COMMIT: `o_REG_WE`=1 for that one phi1 cycle → HOLD.
  - HOLD → IDLE when the busy counter reaches 0.
- **Busy counter**: loaded with BUSY_CYCLES at acceptance, decrements on each enable. `o_BUSY` = (counter ≠ 0) or state ≠ IDLE.
- **Reset mid-operation**: the pending write is discarded and no strobe is issued.

## Timing
- Reset values: `o_BUSY`=0, `o_REG_WE`=0, `o_REG_ADDR`=0x00, `o_REG_DATA`=0x00, `o_SLOT`=0. Address latch = 0x00, FSM = IDLE.
- `o_BUSY` rises within 3 `i_EMUCLK` of the WR_n rising edge: 2 for synchronization, 1 to register.
- Commit latency after acceptance is 1 to 32 enables. Global registers always take 1.
- `o_REG_ADDR`/`o_REG_DATA` change only at the commit enable. They hold their value after the strobe.
- `o_BUSY` falls exactly BUSY_CYCLES enables after acceptance.
- **Simultaneous events**:
  - An address write during WAIT does not alter the pending address.
  - An `i_CYCLE_31` resync during WAIT takes effect before the match check on the next enable.
- With no enables, the FSM and counters freeze. Bus capture continues.

## Configuration
- Macro `IKA2151_REGWR_QUEUE_EN`.
- **Defined**: adds a 1-entry queue.
  - A data write while busy and the queue empty is stored in the queue.
  - On the HOLD→IDLE enable, the queued entry becomes pending: state goes to WAIT, busy reloads, and `o_BUSY` stays high without a gap.
  - A write while the queue is full is ignored.
- **Undefined**: data writes while `o_BUSY`=1 are ignored (chip-accurate).

## Structure
- Shared package `ika2151_pkg` holds:
  - the FSM state enum (IDLE, WAIT, COMMIT, HOLD);
  - the region boundaries 0x20 and 0x40;
  - the default BUSY_CYCLES.
- Sub-module `ika2151_busif_sync`: the 2-stage synchronizer plus write-edge detector. Outputs a one-EMUCLK `wr_pulse` together with a0 and d.

## Test plan
- Reset asserted mid-WAIT for address 0x45 → no `o_REG_WE`; all outputs return to their reset values immediately.
- Write address 0x08, then data 0x7F → `o_REG_WE` on the first enable with ADDR=0x08, DATA=0x7F. `o_BUSY` is high for 32 enables.
- Slot locked via `i_CYCLE_31`; write address 0x5A, then data 0x11 when slot=3 → strobe when `o_SLOT`=26 (23 enables later).
- Write address 0x2B, then data 0xC0 when slot=5 → strobe at slot 11 (first slot with [2:0]=3).
- Second data write 0x22 during HOLD:
  - Macro undefined → ignored; only the first write is committed.
  - Macro defined → committed after the first; `o_BUSY` stays continuously high for 64+ enables.
- Address write to 0x30 during WAIT for 0x45 → commit still uses ADDR=0x45.

Source files
------------

// File: rtl/ika2151_pkg.sv
// ---------------------------------------------------------------------------
// ika2151_pkg
// Shared definitions for the IKA2151 register-write scheduler slice:
//   - sched_state_e : scheduler FSM states (IDLE, WAIT, COMMIT, HOLD)
//   - bus_sample_t  : one synchronized sample of the CPU bus strobes/data
//   - REGION_*      : register-map boundaries (global / channel / operator)
//   - BUSY_CYCLES_DEFAULT : default BUSY length in phi1 cycles
//   - slot_match()  : does a register address belong to a given slot
// ---------------------------------------------------------------------------
package ika2151_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    COMMIT = 2'd2,
    HOLD   = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic       cs_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] d;
  } bus_sample_t;

  // Bus at rest: strobes deasserted, so no false write edge after reset.
  localparam bus_sample_t BUS_IDLE = '{cs_n: 1'b1, wr_n: 1'b1, a0: 1'b0, d: 8'h00};

  // 0x00-0x1F global, 0x20-0x3F channel, 0x40-0xFF operator.
  localparam logic [7:0] REGION_CH_BASE = 8'h20;
  localparam logic [7:0] REGION_OP_BASE = 8'h40;

  localparam int BUSY_CYCLES_DEFAULT = 32;

  // Global registers are shared by every slot; channel registers repeat every
  // 8 slots; operator registers own exactly one of the 32 slots.
  function automatic logic slot_match(input logic [7:0] addr, input logic [4:0] slot);
    logic hit;
    if (addr < REGION_CH_BASE) begin
      hit = 1'b1;
    end else if (addr < REGION_OP_BASE) begin
      hit = (slot[2:0] == addr[2:0]);
    end else begin
      hit = (slot == addr[4:0]);
    end
    return hit;
  endfunction

endpackage

// File: rtl/ika2151_busif_sync.sv
// ---------------------------------------------------------------------------
// ika2151_busif_sync
// Brings the asynchronous CPU bus into the EMUCLK domain through a 2-stage
// synchronizer and detects a write as a rising edge of synchronized WR_n with
// CS_n low. A third register keeps the sample from before the edge, which is
// the one still holding valid A0/D (the CPU may move the bus as WR_n rises).
//
// Ports:
//   clk, rst_n      EMUCLK and asynchronous active-low reset
//   cs_n, wr_n, a0  raw CPU bus strobes and register select
//   d[7:0]          raw CPU write data
//   wr_pulse        one-clk pulse per detected write
//   wr_a0, wr_d     A0 and D belonging to that write (valid with wr_pulse)
// ---------------------------------------------------------------------------
module ika2151_busif_sync
  import ika2151_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] d,
  output logic       wr_pulse,
  output logic       wr_a0,
  output logic [7:0] wr_d
);

  bus_sample_t s1_q, s1_d;
  bus_sample_t s2_q, s2_d;
  bus_sample_t prev_q, prev_d;

  always_comb begin
    s1_d   = '{cs_n: cs_n, wr_n: wr_n, a0: a0, d: d};
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= BUS_IDLE;
      s2_q   <= BUS_IDLE;
      prev_q <= BUS_IDLE;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  // CS_n is qualified with the pre-edge sample so a CS_n released together
  // with WR_n still counts as a valid write.
  assign wr_pulse = !prev_q.wr_n && s2_q.wr_n && !prev_q.cs_n;
  assign wr_a0    = prev_q.a0;
  assign wr_d     = prev_q.d;

endmodule

// File: rtl/ika2151_regwr_sched.sv
// ---------------------------------------------------------------------------
// ika2151_regwr_sched
// Register-write scheduler between the CPU bus and the IKA2151 per-slot
// register file. An address write loads the address latch; a data write
// becomes a pending entry that waits until the local slot counter reaches a
// slot owning the register, then a one-phi1-cycle write strobe is issued.
// BUSY stays high for BUSY_CYCLES phi1 cycles after acceptance.
//
// Optional feature: define IKA2151_REGWR_QUEUE_EN to add a 1-entry queue that
// holds one data write arriving while busy; without it such writes are lost.
//
// Ports:
//   i_EMUCLK       master clock (only clock)
//   i_MRST_n       asynchronous active-low reset
//   i_phi1_NCEN_n  phi1 enable, active-low; scheduler state moves only here
//   i_CYCLE_31     marks the phi1 cycle treated as slot 31
//   i_CS_n, i_WR_n, i_A0, i_D[7:0]   CPU bus
//   o_BUSY         CPU-visible busy flag
//   o_REG_WE       register-file write strobe, one phi1 cycle
//   o_REG_ADDR/o_REG_DATA  committed address/data, held after the strobe
//   o_SLOT         local slot counter
// ---------------------------------------------------------------------------
module ika2151_regwr_sched
  import ika2151_pkg::*;
#(
  parameter int BUSY_CYCLES = BUSY_CYCLES_DEFAULT
) (
  input  logic       i_EMUCLK,
  input  logic       i_MRST_n,
  input  logic       i_phi1_NCEN_n,
  input  logic       i_CYCLE_31,
  input  logic       i_CS_n,
  input  logic       i_WR_n,
  input  logic       i_A0,
  input  logic [7:0] i_D,
  output logic       o_BUSY,
  output logic       o_REG_WE,
  output logic [7:0] o_REG_ADDR,
  output logic [7:0] o_REG_DATA,
  output logic [4:0] o_SLOT
);

  localparam int               CNT_W     = $clog2(BUSY_CYCLES + 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic       phi1_en;
  logic       wr_pulse;
  logic       wr_a0;
  logic [7:0] wr_d;
  logic       sched_free;
  logic       release_sched;

  sched_state_e     state_q, state_d;
  logic [4:0]       slot_q, slot_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic [7:0]       addr_latch_q, addr_latch_d;
  logic [7:0]       pend_addr_q, pend_addr_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic [7:0]       reg_addr_q, reg_addr_d;
  logic [7:0]       reg_data_q, reg_data_d;

`ifdef IKA2151_REGWR_QUEUE_EN
  logic       promote;
  logic       q_valid_q, q_valid_d;
  logic [7:0] q_addr_q, q_addr_d;
  logic [7:0] q_data_q, q_data_d;
`endif

  assign phi1_en = !i_phi1_NCEN_n;

  ika2151_busif_sync u_busif (
    .clk      (i_EMUCLK),
    .rst_n    (i_MRST_n),
    .cs_n     (i_CS_n),
    .wr_n     (i_WR_n),
    .a0       (i_A0),
    .d        (i_D),
    .wr_pulse (wr_pulse),
    .wr_a0    (wr_a0),
    .wr_d     (wr_d)
  );

`ifdef IKA2151_REGWR_QUEUE_EN
  // A queued entry still owns the scheduler even in the IDLE state.
  assign sched_free = (state_q == IDLE) && !q_valid_q;
`else
  assign sched_free = (state_q == IDLE);
`endif

  // Next-state logic. Phi1-enabled work (slot counter, busy countdown, FSM)
  // is evaluated first; bus capture runs every EMUCLK and, when it accepts a
  // write, takes priority so a coinciding enable does not count as the first
  // enable after acceptance.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    busy_cnt_d    = busy_cnt_q;
    addr_latch_d  = addr_latch_q;
    pend_addr_d   = pend_addr_q;
    pend_data_d   = pend_data_q;
    reg_addr_d    = reg_addr_q;
    reg_data_d    = reg_data_q;
    release_sched = 1'b0;
`ifdef IKA2151_REGWR_QUEUE_EN
    q_valid_d     = q_valid_q;
    q_addr_d      = q_addr_q;
    q_data_d      = q_data_q;
    promote       = 1'b0;
`endif

    if (phi1_en) begin
      slot_d = i_CYCLE_31 ? 5'd0 : slot_q + 5'd1;
      if (busy_cnt_q != '0) begin
        busy_cnt_d = busy_cnt_q - CNT_ONE;
      end
      // The match uses the slot being entered, so a CYCLE_31 resync on
      // this enable is already reflected.
      case (state_q)
        IDLE: begin
        end
        WAIT: begin
          if (slot_match(pend_addr_q, slot_d)) begin
            state_d    = COMMIT;
            reg_addr_d = pend_addr_q;
            reg_data_d = pend_data_q;
          end
        end
        COMMIT: begin
          // A commit that landed on the last busy cycle leaves directly.
          if (busy_cnt_q <= CNT_ONE) begin
            release_sched = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (busy_cnt_q <= CNT_ONE) begin
            release_sched = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (release_sched) begin
      state_d = IDLE;
    end

`ifdef IKA2151_REGWR_QUEUE_EN
    // Promoting on the release enable keeps BUSY high without a gap.
    promote = q_valid_q && (release_sched || (state_q == IDLE));
    if (promote) begin
      state_d     = WAIT;
      pend_addr_d = q_addr_q;
      pend_data_d = q_data_q;
      busy_cnt_d  = BUSY_LOAD;
      q_valid_d   = 1'b0;
    end
`endif

    if (wr_pulse) begin
      if (!wr_a0) begin
        addr_latch_d = wr_d;
      end else if (sched_free) begin
        state_d     = WAIT;
        pend_addr_d = addr_latch_q;
        pend_data_d = wr_d;
        busy_cnt_d  = BUSY_LOAD;
      end
`ifdef IKA2151_REGWR_QUEUE_EN
      else if (!q_valid_q) begin
        q_valid_d = 1'b1;
        q_addr_d  = addr_latch_q;
        q_data_d  = wr_d;
      end
`endif
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state_q      <= IDLE;
      slot_q       <= 5'd0;
      busy_cnt_q   <= '0;
      addr_latch_q <= 8'h00;
      pend_addr_q  <= 8'h00;
      pend_data_q  <= 8'h00;
      reg_addr_q   <= 8'h00;
      reg_data_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      busy_cnt_q   <= busy_cnt_d;
      addr_latch_q <= addr_latch_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      reg_addr_q   <= reg_addr_d;
      reg_data_q   <= reg_data_d;
    end
  end

`ifdef IKA2151_REGWR_QUEUE_EN
  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      q_valid_q <= 1'b0;
      q_addr_q  <= 8'h00;
      q_data_q  <= 8'h00;
    end else begin
      q_valid_q <= q_valid_d;
      q_addr_q  <= q_addr_d;
      q_data_q  <= q_data_d;
    end
  end

  assign o_BUSY = (busy_cnt_q != '0) || (state_q != IDLE) || q_valid_q;
`else
  assign o_BUSY = (busy_cnt_q != '0) || (state_q != IDLE);
`endif

  assign o_REG_WE   = (state_q == COMMIT);
  assign o_REG_ADDR = reg_addr_q;
  assign o_REG_DATA = reg_data_q;
  assign o_SLOT     = slot_q;

endmodule

// File: tb/tb_ika2151_regwr_sched.sv
// ---------------------------------------------------------------------------
// tb_ika2151_regwr_sched
// Self-checking bench for ika2151_regwr_sched. A behavioural model tracks the
// slot position, the pending/queued write, the strobe and the remaining busy
// time per phi1 enable; a compare process checks every DUT output against it
// on each EMUCLK falling edge. Directed scenarios pin the model with literal
// expectations, then a randomized phase mixes enables, resyncs and bus writes.
// Honours IKA2151_REGWR_QUEUE_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_ika2151_regwr_sched;

  localparam int B = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ncen;
  logic       c31;
  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] d;
  logic       o_BUSY;
  logic       o_REG_WE;
  logic [7:0] o_REG_ADDR;
  logic [7:0] o_REG_DATA;
  logic [4:0] o_SLOT;

  ika2151_regwr_sched #(.BUSY_CYCLES(B)) dut (
    .i_EMUCLK      (clk),
    .i_MRST_n      (rst_n),
    .i_phi1_NCEN_n (ncen),
    .i_CYCLE_31    (c31),
    .i_CS_n        (cs_n),
    .i_WR_n        (wr_n),
    .i_A0          (a0),
    .i_D           (d),
    .o_BUSY        (o_BUSY),
    .o_REG_WE      (o_REG_WE),
    .o_REG_ADDR    (o_REG_ADDR),
    .o_REG_DATA    (o_REG_DATA),
    .o_SLOT        (o_SLOT)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Behavioural model state
  int         m_slot;
  int         m_busy_left;
  bit         m_pending;
  bit         m_strobe;
  bit         m_q_valid;
  logic [7:0] m_paddr, m_pdata, m_qaddr, m_qdata;
  logic [7:0] m_raddr, m_rdata, m_alatch;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s: actual='h%0h expected='h%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit m_match(input int addr, input int slot);
    if (addr < 32) return 1'b1;
    else if (addr < 64) return (slot % 8) == (addr % 8);
    else return slot == (addr % 32);
  endfunction

  function automatic bit m_busy();
    return (m_busy_left > 0) || m_pending || m_strobe || m_q_valid;
  endfunction

  task automatic modelReset();
    m_slot = 0; m_busy_left = 0; m_pending = 0; m_strobe = 0; m_q_valid = 0;
    m_paddr = 0; m_pdata = 0; m_qaddr = 0; m_qdata = 0;
    m_raddr = 0; m_rdata = 0; m_alatch = 0;
  endtask

  task automatic modelEnable(input bit c31v);
    m_strobe = 0;
    if (m_busy_left > 0) m_busy_left--;
    m_slot = c31v ? 0 : (m_slot + 1) % 32;
    if (m_pending && m_match(int'(m_paddr), m_slot)) begin
      m_pending = 0;
      m_strobe  = 1;
      m_raddr   = m_paddr;
      m_rdata   = m_pdata;
    end else if (!m_pending && m_busy_left == 0 && m_q_valid) begin
      m_q_valid   = 0;
      m_pending   = 1;
      m_paddr     = m_qaddr;
      m_pdata     = m_qdata;
      m_busy_left = B;
    end
  endtask

  task automatic modelBus(input bit a0v, input logic [7:0] dv, input bit csl);
    if (!csl) return;
    if (!a0v) begin
      m_alatch = dv;
    end else if (!m_busy()) begin
      m_pending   = 1;
      m_paddr     = m_alatch;
      m_pdata     = dv;
      m_busy_left = B;
    end
`ifdef IKA2151_REGWR_QUEUE_EN
    else if (!m_q_valid) begin
      m_q_valid = 1;
      m_qaddr   = m_alatch;
      m_qdata   = dv;
    end
`endif
  endtask

  // Compare process: every outputs-stable point against the model.
  always @(negedge clk) begin
    if (check_en && rst_n) begin
      checkOutput("busy", o_BUSY, m_busy());
      checkOutput("we", o_REG_WE, m_strobe);
      checkOutput("addr", o_REG_ADDR, m_raddr);
      checkOutput("data", o_REG_DATA, m_rdata);
      checkOutput("slot", o_SLOT, m_slot);
    end
  end

  // One phi1 enable; CYCLE_31 follows the model's slot 31 unless forced.
  task automatic doEnable(input bit extra_c31);
    @(negedge clk);
    ncen = 1'b0;
    c31  = (m_slot == 31) || extra_c31;
    @(posedge clk);
    #1 modelEnable(c31);
    @(negedge clk);
    ncen = 1'b1;
    c31  = 1'b0;
  endtask

  // CPU bus write with no enables in between; D changes as WR_n rises.
  task automatic busWrite(input bit a0v, input logic [7:0] dv, input bit csl);
    bit saved;
    bit will_accept;
    saved       = check_en;
    check_en    = 1'b0;
    will_accept = csl && a0v && !m_busy();
    @(negedge clk);
    cs_n = !csl; a0 = a0v; d = dv; wr_n = 1'b0;
    repeat (3) @(negedge clk);
    wr_n = 1'b1;
    d    = ~dv;
    repeat (3) @(posedge clk);
    #1;
    if (will_accept) checkOutput("busy_rise", o_BUSY, 1);
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    modelBus(a0v, dv, csl);
    check_en = saved;
  endtask

  task automatic doReset();
    check_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", o_BUSY, 0);
    checkOutput("rst_we", o_REG_WE, 0);
    checkOutput("rst_addr", o_REG_ADDR, 0);
    checkOutput("rst_data", o_REG_DATA, 0);
    checkOutput("rst_slot", o_SLOT, 0);
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_en = 1'b1;
  endtask

  task automatic runToSlot(input int target);
    for (int i = 0; i < 64; i++) begin
      if (m_slot == target) break;
      doEnable(1'b0);
    end
  endtask

  task automatic drainIdle();
    for (int i = 0; i < 100; i++) begin
      if (!o_BUSY) break;
      doEnable(1'b0);
    end
    checkOutput("drain_idle", o_BUSY, 0);
  endtask

  task automatic waitStrobe(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      doEnable(1'b0);
      if (o_REG_WE) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input int steps);
    int r;
    logic [7:0] v;
    for (int s = 0; s < steps; s++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        doEnable($urandom_range(0, 39) == 0);
      end else if (r < 82) begin
        case ($urandom_range(0, 2))
          0: v = 8'($urandom_range(8'h00, 8'h1F));
          1: v = 8'($urandom_range(8'h20, 8'h3F));
          default: v = 8'($urandom_range(8'h40, 8'hFF));
        endcase
        busWrite(1'b0, v, $urandom_range(0, 9) != 0);
      end else begin
        busWrite(1'b1, 8'($urandom), $urandom_range(0, 9) != 0);
      end
    end
  endtask

  int n;
  int fall;
  int strb;

  initial begin
    rst_n = 1'b0; ncen = 1'b1; c31 = 1'b0;
    cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; d = 8'h00;
    modelReset();
    doReset();

    // Global register: commits on the first enable, busy for 32 enables.
    busWrite(1'b0, 8'h08, 1'b1);
    busWrite(1'b1, 8'h7F, 1'b1);
    doEnable(1'b0);
    checkOutput("t2_we", o_REG_WE, 1);
    checkOutput("t2_addr", o_REG_ADDR, 'h08);
    checkOutput("t2_data", o_REG_DATA, 'h7F);
    fall = -1;
    for (int i = 2; i <= 40; i++) begin
      doEnable(1'b0);
      if (i == 2) begin
        checkOutput("t2_we_off", o_REG_WE, 0);
        checkOutput("t2_addr_hold", o_REG_ADDR, 'h08);
      end
      if (!o_BUSY) begin
        fall = i;
        break;
      end
    end
    checkOutput("t2_busy_len", fall, 32);

    // Operator register 0x5A from slot 3 -> slot 26.
    drainIdle();
    runToSlot(3);
    busWrite(1'b0, 8'h5A, 1'b1);
    busWrite(1'b1, 8'h11, 1'b1);
    waitStrobe(40, n);
    checkOutput("t3_latency", n, 23);
    checkOutput("t3_slot", o_SLOT, 26);
    checkOutput("t3_addr", o_REG_ADDR, 'h5A);
    checkOutput("t3_data", o_REG_DATA, 'h11);

    // Channel register 0x2B from slot 5 -> slot 11.
    drainIdle();
    runToSlot(5);
    busWrite(1'b0, 8'h2B, 1'b1);
    busWrite(1'b1, 8'hC0, 1'b1);
    waitStrobe(40, n);
    checkOutput("t4_latency", n, 6);
    checkOutput("t4_slot", o_SLOT, 11);
    checkOutput("t4_data", o_REG_DATA, 'hC0);

    // Second data write during HOLD.
    drainIdle();
    busWrite(1'b0, 8'h10, 1'b1);
    busWrite(1'b1, 8'h55, 1'b1);
    fall = -1;
    strb = 0;
    for (int i = 1; i <= 100; i++) begin
      doEnable(1'b0);
      if (o_REG_WE) strb++;
      if (i == 2) busWrite(1'b1, 8'h22, 1'b1);
      if (!o_BUSY) begin
        fall = i;
        break;
      end
    end
`ifdef IKA2151_REGWR_QUEUE_EN
    checkOutput("t5_busy_len", fall, 64);
    checkOutput("t5_strobes", strb, 2);
    checkOutput("t5_last_data", o_REG_DATA, 'h22);
`else
    checkOutput("t5_busy_len", fall, 32);
    checkOutput("t5_strobes", strb, 1);
    checkOutput("t5_last_data", o_REG_DATA, 'h55);
`endif

    // Address write during WAIT must not disturb the pending address.
    drainIdle();
    runToSlot(10);
    busWrite(1'b0, 8'h45, 1'b1);
    busWrite(1'b1, 8'h99, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("t6_freeze_slot", o_SLOT, 10);
    checkOutput("t6_freeze_busy", o_BUSY, 1);
    repeat (3) doEnable(1'b0);
    busWrite(1'b0, 8'h30, 1'b1);
    waitStrobe(40, n);
    checkOutput("t6_latency", n, 24);
    checkOutput("t6_addr", o_REG_ADDR, 'h45);
    checkOutput("t6_data", o_REG_DATA, 'h99);
    checkOutput("t6_slot", o_SLOT, 5);

    // Reset in the middle of WAIT discards the write.
    drainIdle();
    runToSlot(10);
    busWrite(1'b0, 8'h45, 1'b1);
    busWrite(1'b1, 8'h66, 1'b1);
    repeat (3) doEnable(1'b0);
    doReset();
    strb = 0;
    for (int i = 0; i < 40; i++) begin
      doEnable(1'b0);
      if (o_REG_WE) strb++;
    end
    checkOutput("t7_no_strobe", strb, 0);
    checkOutput("t7_addr", o_REG_ADDR, 0);

    // Randomized traffic against the model.
    applyStimulus(1500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
